// File: rtl/pixel_fetch_scheduler.sv
// pixel_fetch_scheduler
// Walks a row-major grid of fetch positions over a rectangular image region,
// triggers parallel_pixel_fetch once per position, and holds each fetched
// tile for the PE array under a valid/ready handshake before advancing.
// Optional watchdog: define PPF_TIMEOUT_EN to abandon a fetch that does not
// complete within TIMEOUT cycles and raise the sticky err flag.
module pixel_fetch_scheduler #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_row_pitch,
  input  logic [ADDR_WIDTH-1:0] cfg_col_step,
  input  logic [CNT_WIDTH-1:0]  cfg_cols,
  input  logic [CNT_WIDTH-1:0]  cfg_rows,
  output logic                  fetch_en,
  output logic                  fetch_start,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] row_offset,
  output logic [ADDR_WIDTH-1:0] col_offset,
  input  logic                  fetch_done,
  output logic                  tile_valid,
  input  logic                  pe_ready,
  output logic [CNT_WIDTH-1:0]  row_idx,
  output logic [CNT_WIDTH-1:0]  col_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]            state_r;
  logic [2:0]            state_s;
  logic [ADDR_WIDTH-1:0] base_addr_r;
  logic [ADDR_WIDTH-1:0] row_offset_r;
  logic [ADDR_WIDTH-1:0] col_offset_r;
  logic [ADDR_WIDTH-1:0] row_pitch_r;
  logic [ADDR_WIDTH-1:0] col_step_r;
  logic [CNT_WIDTH-1:0]  cols_r;
  logic [CNT_WIDTH-1:0]  rows_r;
  logic [CNT_WIDTH-1:0]  row_idx_r;
  logic [CNT_WIDTH-1:0]  col_idx_r;
  logic                  done_r;
  logic                  err_r;

  logic zero_cfg_s;
  logic accept_s;
  logic zero_start_s;
  logic advance_s;
  logic last_col_s;
  logic last_row_s;
  logic timeout_hit_s;

  assign zero_cfg_s   = (cfg_cols == {CNT_WIDTH{1'b0}}) || (cfg_rows == {CNT_WIDTH{1'b0}});
  assign accept_s     = (state_r == ST_IDLE) && start && !zero_cfg_s && !abort;
  assign zero_start_s = (state_r == ST_IDLE) && start && zero_cfg_s && !abort;
  assign advance_s    = (state_r == ST_HOLD) && pe_ready && !abort;
  // Compare against the latched geometry so mid-scan config edits are inert.
  assign last_col_s   = (col_idx_r == (cols_r - CNT_WIDTH'(1)));
  assign last_row_s   = (row_idx_r == (rows_r - CNT_WIDTH'(1)));

`ifdef PPF_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TO_W-1:0] wd_cnt_r;

  assign timeout_hit_s = (state_r == ST_WAIT) && !fetch_done &&
                         (wd_cnt_r == TO_W'(TIMEOUT - 1));

  // Watchdog: counts cycles spent in WAIT, held at zero elsewhere so each entry starts fresh.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt_r <= {TO_W{1'b0}};
    end else if (state_r != ST_WAIT) begin
      wd_cnt_r <= {TO_W{1'b0}};
    end else begin
      wd_cnt_r <= wd_cnt_r + TO_W'(1);
    end
  end

  // Sticky timeout flag: cleared only by reset or an accepted scan start; abort leaves it alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= 1'b0;
    end else if (timeout_hit_s && !abort) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  assign timeout_hit_s = 1'b0;

  // Without the watchdog the error flag can never be raised.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_r <= 1'b0;
    end else begin
      err_r <= 1'b0;
    end
  end
`endif

  // Scan sequencer state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; abort overrides every other input.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_s = ST_ISSUE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ISSUE: state_s = ST_WAIT;
        ST_WAIT: begin
          if (fetch_done) begin
            state_s = ST_HOLD;
          end else if (timeout_hit_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (!pe_ready) begin
            state_s = ST_HOLD;
          end else if (last_col_s && last_row_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ISSUE;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Position counters, accumulated offsets and latched configuration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_addr_r  <= {ADDR_WIDTH{1'b0}};
      row_pitch_r  <= {ADDR_WIDTH{1'b0}};
      col_step_r   <= {ADDR_WIDTH{1'b0}};
      cols_r       <= {CNT_WIDTH{1'b0}};
      rows_r       <= {CNT_WIDTH{1'b0}};
      row_idx_r    <= {CNT_WIDTH{1'b0}};
      col_idx_r    <= {CNT_WIDTH{1'b0}};
      row_offset_r <= {ADDR_WIDTH{1'b0}};
      col_offset_r <= {ADDR_WIDTH{1'b0}};
    end else if (accept_s) begin
      base_addr_r  <= cfg_base_addr;
      row_pitch_r  <= cfg_row_pitch;
      col_step_r   <= cfg_col_step;
      cols_r       <= cfg_cols;
      rows_r       <= cfg_rows;
      row_idx_r    <= {CNT_WIDTH{1'b0}};
      col_idx_r    <= {CNT_WIDTH{1'b0}};
      row_offset_r <= {ADDR_WIDTH{1'b0}};
      col_offset_r <= {ADDR_WIDTH{1'b0}};
    end else if (advance_s && !last_col_s) begin
      col_idx_r    <= col_idx_r + CNT_WIDTH'(1);
      col_offset_r <= col_offset_r + col_step_r;
    end else if (advance_s && !last_row_s) begin
      col_idx_r    <= {CNT_WIDTH{1'b0}};
      col_offset_r <= {ADDR_WIDTH{1'b0}};
      row_idx_r    <= row_idx_r + CNT_WIDTH'(1);
      row_offset_r <= row_offset_r + row_pitch_r;
    end else begin
      col_idx_r    <= col_idx_r;
    end
  end

  // Completion pulse: end of a full scan, or immediately for a zero-sized region.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_r <= 1'b0;
    end else if (zero_start_s) begin
      done_r <= 1'b1;
    end else if (advance_s && last_col_s && last_row_s) begin
      done_r <= 1'b1;
    end else begin
      done_r <= 1'b0;
    end
  end

  assign fetch_start = (state_r == ST_ISSUE);
  assign tile_valid  = (state_r == ST_HOLD);
  assign busy        = (state_r == ST_ISSUE) || (state_r == ST_WAIT) || (state_r == ST_HOLD);
  assign fetch_en    = busy;
  assign base_addr   = base_addr_r;
  assign row_offset  = row_offset_r;
  assign col_offset  = col_offset_r;
  assign row_idx     = row_idx_r;
  assign col_idx     = col_idx_r;
  assign done        = done_r;
  assign err         = err_r;

endmodule

// File: tb/tb_pixel_fetch_scheduler.sv
// Scoreboard bench for pixel_fetch_scheduler: scans are expanded into the
// expected list of (effective address, row, col) fetches by plain nested
// loops; a monitor pops and compares on every fetch_start and done pulse.
module tb_pixel_fetch_scheduler;

  localparam int AW = 12;
  localparam int CW = 8;
  localparam int TO = 16;

  logic          clk;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [AW-1:0] cfg_base_addr;
  logic [AW-1:0] cfg_row_pitch;
  logic [AW-1:0] cfg_col_step;
  logic [CW-1:0] cfg_cols;
  logic [CW-1:0] cfg_rows;
  logic          fetch_en;
  logic          fetch_start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] row_offset;
  logic [AW-1:0] col_offset;
  logic          fetch_done;
  logic          tile_valid;
  logic          pe_ready;
  logic [CW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic          busy;
  logic          done;
  logic          err;

  pixel_fetch_scheduler #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_row_pitch(cfg_row_pitch),
    .cfg_col_step(cfg_col_step), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .fetch_en(fetch_en), .fetch_start(fetch_start), .base_addr(base_addr),
    .row_offset(row_offset), .col_offset(col_offset), .fetch_done(fetch_done),
    .tile_valid(tile_valid), .pe_ready(pe_ready), .row_idx(row_idx),
    .col_idx(col_idx), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [27:0] exp_q[$];   // {addr[11:0], row[7:0], col[7:0]}
  int exp_done  = 0;
  int done_seen = 0;
  int checks    = 0;
  int errors    = 0;

  // Responder controls (stimulus writes, responder reads)
  bit rand_ready = 1'b0;
  bit resp_off   = 1'b0;
  int bp_len     = 0;
  int bp_req_id  = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: one entry per grid position in row-major order.
  task automatic push_scan(input logic [AW-1:0] base, input logic [AW-1:0] pitch,
                           input logic [AW-1:0] step, input int cols, input int rows);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        logic [AW-1:0] a;
        a = AW'(int'(base) + r * int'(pitch) + c * int'(step));
        exp_q.push_back({a, CW'(r), CW'(c)});
      end
    end
  endtask

  // Monitor: compares every fetch and completion against the scoreboard.
  logic          stall_prev = 1'b0;
  logic [CW-1:0] prev_col, prev_row;
  always @(negedge clk) begin
    if (rstn) begin
      if (stall_prev) begin
        check("stall_hold", {tile_valid, fetch_start, row_idx, col_idx},
              {1'b1, 1'b0, prev_row, prev_col});
      end
      if (fetch_start) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fetch", 1, 0);
        end else begin
          logic [27:0] e;
          e = exp_q.pop_front();
          check("fetch_addr", AW'(base_addr + row_offset + col_offset), e[27:16]);
          check("fetch_pos", {row_idx, col_idx}, e[15:0]);
        end
      end
      if (done) begin
        done_seen++;
        if (exp_done == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_done--;
          check("done_not_busy", {busy, fetch_en}, 2'b00);
        end
      end
      stall_prev = tile_valid && !pe_ready && !abort;
      prev_col   = col_idx;
      prev_row   = row_idx;
    end
  end

  // Fetch-engine and PE-array responder.
  initial begin
    int pending;
    int lat;
    int bp_left;
    int bp_ack;
    pending = 0; lat = 0; bp_left = 0; bp_ack = 0;
    fetch_done = 1'b0;
    pe_ready   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bp_req_id != bp_ack) begin
        bp_left = bp_len;
        bp_ack  = bp_req_id;
      end
      if (resp_off) begin
        pending = 0; fetch_done = 1'b0;
      end else if (fetch_start) begin
        pending = 1; lat = $urandom_range(1, 4); fetch_done = 1'b0;
      end else if (pending != 0) begin
        lat--;
        if (lat == 0) begin fetch_done = 1'b1; pending = 0; end
        else fetch_done = 1'b0;
      end else begin
        fetch_done = 1'b0;
      end
      if (tile_valid && bp_left > 0) begin
        pe_ready = 1'b0; bp_left--;
      end else if (rand_ready) begin
        pe_ready = 1'($urandom_range(0, 1));
      end else begin
        pe_ready = 1'b1;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_scan_end(input int prev_done);
    int n;
    n = 0;
    while (done_seen == prev_done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done_seen != prev_done, 1);
    check("idle_after_scan", {busy, fetch_en, tile_valid}, 3'b000);
    check("fetches_remaining", exp_q.size(), 0);
  endtask

  task automatic run_scan(input logic [AW-1:0] base, input logic [AW-1:0] pitch,
                          input logic [AW-1:0] step, input logic [CW-1:0] cols,
                          input logic [CW-1:0] rows, input int bp, input bit poke);
    int prev;
    prev = done_seen;
    push_scan(base, pitch, step, int'(cols), int'(rows));
    exp_done++;
    if (bp > 0) begin bp_len = bp; bp_req_id++; end
    cfg_base_addr = base; cfg_row_pitch = pitch; cfg_col_step = step;
    cfg_cols = cols; cfg_rows = rows;
    pulse_start();
    check("start_latency", {fetch_start, busy, fetch_en}, 3'b111);
    // Config edits after acceptance must not affect the running scan.
    cfg_base_addr = AW'($urandom); cfg_row_pitch = AW'($urandom);
    cfg_col_step = AW'($urandom); cfg_cols = CW'($urandom_range(1, 9));
    cfg_rows = CW'($urandom_range(1, 9));
    if (poke) begin
      repeat (3) begin @(posedge clk); #1; end
      check("busy_before_poke", busy, 1);
      pulse_start();
    end
    wait_scan_end(prev);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_base_addr = '0; cfg_row_pitch = '0; cfg_col_step = '0;
    cfg_cols = '0; cfg_rows = '0;
    #3;
    check("reset_outputs",
          {fetch_en, fetch_start, base_addr, row_offset, col_offset, tile_valid,
           row_idx, col_idx, busy, done, err}, 64'd0);
    #20 rstn = 1'b1;
    @(posedge clk); #1;

    // Basic scan
    rand_ready = 1'b0;
    run_scan(12'h010, 12'h004, 12'h001, 8'd3, 8'd2, 0, 1'b0);

    // Backpressure on the first tile
    run_scan(12'h010, 12'h004, 12'h001, 8'd3, 8'd2, 5, 1'b0);

    // Zero dimension: cols=0, then rows=0
    for (int k = 0; k < 2; k++) begin
      cfg_cols = (k == 0) ? 8'd0 : 8'd3;
      cfg_rows = (k == 0) ? 8'd2 : 8'd0;
      exp_done++;
      pulse_start();
      check("zero_dim_done", {done, busy, fetch_start}, 3'b100);
      @(posedge clk); #1;
      check("zero_dim_after", {done, busy, fetch_start}, 3'b000);
    end

    // Abort in WAIT of the 4th fetch, then restart from the origin
    begin
      int cnt;
      int n;
      push_scan(12'h020, 12'h008, 12'h002, 3, 2);
      exp_done++;
      cfg_base_addr = 12'h020; cfg_row_pitch = 12'h008; cfg_col_step = 12'h002;
      cfg_cols = 8'd3; cfg_rows = 8'd2;
      pulse_start();
      cnt = fetch_start ? 1 : 0;
      n = 0;
      while (cnt < 4 && n < 500) begin
        @(posedge clk); #1;
        n++;
        if (fetch_start) cnt++;
      end
      check("abort_reached_4th", cnt, 4);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_idle", {busy, fetch_en, tile_valid, done}, 4'b0000);
      exp_q.delete();
      exp_done--;
      repeat (10) begin @(posedge clk); #1; end
      check("abort_stays_idle", {busy, fetch_en}, 2'b00);
      run_scan(12'h030, 12'h010, 12'h001, 8'd2, 8'd2, 0, 1'b0);
    end

    // Address wrap with a start pulse during the scan
    run_scan(12'hFFE, 12'h000, 12'h001, 8'd4, 8'd1, 0, 1'b1);

    // Randomized scans with random PE backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_scan(AW'($urandom), AW'($urandom), AW'($urandom),
               CW'($urandom_range(1, 4)), CW'($urandom_range(1, 3)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;

`ifdef PPF_TIMEOUT_EN
    // Watchdog: fetch never completes
    begin
      int n;
      resp_off = 1'b1;
      push_scan(12'h040, 12'h000, 12'h001, 1, 1);
      cfg_base_addr = 12'h040; cfg_cols = 8'd1; cfg_rows = 8'd1;
      pulse_start();
      @(posedge clk); #1;
      n = 0;
      while (!err && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("timeout_cycles", n, TO);
      check("timeout_idle", {err, busy, done}, 3'b100);
      repeat (3) begin @(posedge clk); #1; end
      check("err_sticky", err, 1);
      resp_off = 1'b0;
      run_scan(12'h050, 12'h000, 12'h001, 8'd1, 8'd1, 0, 1'b0);
      check("err_cleared_by_start", err, 0);
    end
`else
    check("err_tied_low", err, 0);
`endif

    repeat (5) begin @(posedge clk); #1; end
    check("no_pending_done", exp_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/pixel_fetch_scheduler.md
Name: pixel_fetch_scheduler

Overview:
Sequencer that drives the parallel_pixel_fetch block across a rectangular image region.
- Walks a row-major grid of fetch positions and issues one fetch_start pulse per position.
- Waits for fetch_done, then holds the fetched tile for the PE array under a valid/ready handshake before advancing.
- Sits between the control FSM (start/abort/config) and parallel_pixel_fetch; the PE array consumes the fetched words directly.

Parameters:
ADDR_WIDTH, 12, width of base/row/col address fields (matches parallel_pixel_fetch).
CNT_WIDTH, 8, width of row/column position counters.
TIMEOUT, 64, watchdog limit in cycles; used only with PPF_TIMEOUT_EN.

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a scan; ignored while busy=1
abort  in  1  synchronous abort; return to IDLE
cfg_base_addr  in  ADDR_WIDTH  region base word address
cfg_row_pitch  in  ADDR_WIDTH  word-address increment per row
cfg_col_step  in  ADDR_WIDTH  word-address increment per column
cfg_cols  in  CNT_WIDTH  fetches per row
cfg_rows  in  CNT_WIDTH  rows to scan
fetch_en  out  1  enable to parallel_pixel_fetch
fetch_start  out  1  single-cycle fetch trigger
base_addr  out  ADDR_WIDTH  latched cfg_base_addr
row_offset  out  ADDR_WIDTH  row × cfg_row_pitch (accumulated)
col_offset  out  ADDR_WIDTH  col × cfg_col_step (accumulated)
fetch_done  in  1  completion pulse from parallel_pixel_fetch
tile_valid  out  1  fetched tile held for the PE array
pe_ready  in  1  PE array accepts the tile
row_idx  out  CNT_WIDTH  current row position
col_idx  out  CNT_WIDTH  current column position
busy  out  1  scan in progress
done  out  1  single-cycle pulse when a scan completes
err  out  1  sticky timeout flag (PPF_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE. All outputs 0: fetch_en, fetch_start, base_addr, row_offset, col_offset, tile_valid, row_idx, col_idx, busy, done, err.
- All outputs are registered or decoded from state. fetch_en = busy.
- IDLE: on start=1:
  - If cfg_cols==0 or cfg_rows==0: pulse done in the next cycle and stay in IDLE.
  - Otherwise: latch all cfg_* inputs; clear row_idx, col_idx, row_offset, col_offset; go to ISSUE.
- ISSUE: fetch_start=1 for exactly one cycle; offsets are stable in that cycle; next state WAIT. Latency: start sampled at edge N → fetch_start high during cycle N+1.
- WAIT: stay until fetch_done=1, then go to HOLD. A fetch_done seen in any other state is ignored.
- HOLD: tile_valid=1. Advance on the edge where tile_valid && pe_ready, then deassert tile_valid:
  - col_idx < cols-1: col_idx+1, col_offset += col_step; go to ISSUE.
  - col_idx == cols-1 and row_idx < rows-1: col_idx=0, col_offset=0, row_idx+1, row_offset += row_pitch; go to ISSUE.
  - Last position: go to DONE.
- DONE: done=1 for one cycle, busy=0; next state IDLE. A start in this cycle is ignored.
- Throughput: at most one fetch per (ISSUE + WAIT + HOLD). With pe_ready held high, minimum spacing between fetch_start pulses = fetch latency + 2 cycles.
- Arithmetic: offset adds are modulo 2^ADDR_WIDTH; wrap-around is silent. Counters compare against latched config, so config changes mid-scan have no effect.
- abort=1 in any state: next state IDLE; fetch_en, tile_valid, busy drop next cycle; done not pulsed; err retained. abort has priority over start, fetch_done and pe_ready in the same cycle.
- pe_ready is ignored outside HOLD.

Optional Feature:
PPF_TIMEOUT_EN defined:
- A cycle counter runs in WAIT and clears on entry to WAIT.
- If it reaches TIMEOUT without fetch_done: set err=1 (sticky until reset or the next accepted start), go to IDLE, no done pulse.
Undefined: no counter; WAIT waits indefinitely; err is constant 0.

Test Plan:
- Basic scan: base=0x10, pitch=4, step=1, cols=3, rows=2, pe_ready=1 → six fetch_start pulses at effective addresses 0x10, 0x11, 0x12, 0x14, 0x15, 0x16; one done pulse; busy low afterwards.
- Backpressure: pe_ready=0 for 5 cycles after the first fetch_done → tile_valid held for 5 cycles; no fetch_start, no change in col_idx; advance on the first cycle pe_ready=1.
- Zero dimension: start with cfg_cols=0 → done pulse the next cycle; fetch_start never asserts; busy stays 0.
- Abort mid-scan: assert abort in WAIT of the 4th fetch → IDLE next cycle; fetch_en=0; no done; a new start then begins at row 0, col 0.
- Wrap and start-while-busy: base=0xFFE, step=1, cols=4, rows=1 → effective addresses 0xFFE, 0xFFF, 0x000, 0x001; a start pulse during the scan has no effect.
- Timeout (PPF_TIMEOUT_EN, TIMEOUT=16): fetch_done held 0 → err=1 exactly 16 cycles after entering WAIT; state IDLE; no done pulse.
